// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch front end.
//   fetch_entry_t   - one buffered instruction {pc, inst}
//   NopInst         - bubble instruction (addi x0,x0,0)
//   DefaultResetPc  - default first fetch address
//   region_is_bios  - PC region decode (1 = BIOS, 0 = IMEM)
package fetch_pkg;

  localparam int unsigned FetchXlen      = 32;
  localparam logic [31:0] NopInst        = 32'h0000_0013;
  localparam logic [31:0] DefaultResetPc = 32'h4000_0000;

  typedef struct packed {
    logic [FetchXlen-1:0] pc;
    logic [FetchXlen-1:0] inst;
  } fetch_entry_t;

  // PC is zero-extended to 64 bits so the helper works for any XLEN up to 64.
  function automatic logic region_is_bios(input logic [63:0] pc, input int unsigned sel_bit);
    return pc[sel_bit[5:0]];
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: DEPTH-entry circular buffer of fetched instructions.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write push_entry at the tail
//   push_entry  - entry to write
//   pop         - drop the head entry (only asserted while non-empty)
//   flush       - discard all entries; a concurrent push becomes the only entry
//   count       - number of valid entries
//   head        - oldest entry (meaningless while count == 0)
module fetch_skid_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CntW = $clog2(DEPTH + 1),
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  fetch_entry_t    push_entry,
  input  logic            pop,
  input  logic            flush,
  output logic [CntW-1:0] count,
  output fetch_entry_t    head
);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_write;
  logic [PtrW-1:0] wr_slot;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_write = push;
    wr_slot  = wr_ptr_q;
    if (flush) begin
      // Restart from slot 0; a simultaneous push (redirect bubble) lands there.
      rd_ptr_d = '0;
      wr_slot  = '0;
      wr_ptr_d = push ? PtrW'(1) : '0;
      count_d  = push ? CntW'(1) : '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_slot] <= push_entry;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end. Owns the fetch PC, issues one synchronous read per
// cycle to BIOS or IMEM (chosen by PC bit BIOS_SEL_BIT), buffers returns in a skid FIFO and
// hands them to decode over a valid/ready handshake. Redirects flush buffered and in-flight work.
// Optional feature: define FETCH_REDIRECT_NOP_EN to insert one NOP bubble entry ahead of each
// redirect target.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   redirect_valid/redirect_pc - redirect fetch this cycle (pc[1:0] ignored)
//   bios_en/bios_addr/bios_dout - BIOS read port (data one cycle after enable)
//   imem_en/imem_addr/imem_dout - IMEM read port (data one cycle after enable)
//   out_valid/out_ready        - decode handshake
//   out_pc/out_inst            - presented instruction and its PC
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN         = FetchXlen,
  parameter int unsigned     BIOS_AW      = 12,
  parameter int unsigned     IMEM_AW      = 14,
  parameter logic [XLEN-1:0] RESET_PC     = XLEN'(DefaultResetPc),
  parameter int unsigned     BIOS_SEL_BIT = 30,
  parameter int unsigned     DEPTH        = 2,
  parameter logic [XLEN-1:0] NOP_INST     = XLEN'(NopInst)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               bios_en,
  output logic [BIOS_AW-1:0] bios_addr,
  input  logic [XLEN-1:0]    bios_dout,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_dout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_inst
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q;
  logic            req_valid_q;
  logic            req_sel_q;
  logic [XLEN-1:0] issue_pc;
  logic            sel;
  logic            issue;
  logic            pop;
  logic            push;
  logic [XLEN-1:0] ret_inst;
  logic [CntW-1:0] count;
  logic [CntW:0]   occupancy;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Credit rule: an issue is allowed only if its return is guaranteed a FIFO slot, counting
  // the read already in flight and a pop happening this cycle. Redirects always issue because
  // they flush everything ahead of them.
  always_comb begin
    issue_pc  = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : pc_q;
    sel       = region_is_bios(64'(issue_pc), BIOS_SEL_BIT);
    pop       = out_valid & out_ready;
    occupancy = (CntW + 1)'(count) + (CntW + 1)'(req_valid_q);
    // Gating with rst_n keeps both enables low while reset is held.
    issue     = rst_n & (redirect_valid |
                         (occupancy < ((CntW + 1)'(DEPTH) + (CntW + 1)'(pop))));
    pc_d      = issue ? issue_pc + XLEN'(4) : pc_q;
  end

  assign bios_en   = issue & sel;
  assign imem_en   = issue & ~sel;
  assign bios_addr = issue_pc[BIOS_AW+1:2];
  assign imem_addr = issue_pc[IMEM_AW+1:2];

  // Registered req_sel steers the return, so region crossings need no bubble.
  always_comb begin
    ret_inst        = req_sel_q ? bios_dout : imem_dout;
    push_entry.pc   = FetchXlen'(req_pc_q);
    push_entry.inst = FetchXlen'(ret_inst);
`ifdef FETCH_REDIRECT_NOP_EN
    // The bubble is written during the redirect cycle so decode sees it one cycle later.
    push = req_valid_q | redirect_valid;
    if (redirect_valid) begin
      push_entry.pc   = '0;
      push_entry.inst = FetchXlen'(NOP_INST);
    end
`else
    // A return arriving with a redirect belongs to the abandoned path.
    push = req_valid_q & ~redirect_valid;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      req_sel_q   <= 1'b0;
      req_pc_q    <= '0;
    end else begin
      pc_q        <= pc_d;
      req_valid_q <= issue;
      if (issue) begin
        req_pc_q  <= issue_pc;
        req_sel_q <= sel;
      end
    end
  end

  fetch_skid_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? XLEN'(head.pc) : '0;
  assign out_inst  = out_valid ? XLEN'(head.inst) : NOP_INST;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage. The stimulus thread queues the expected
// {pc, inst} stream; a monitor pops and compares on every accepted handshake.
// Build with FETCH_REDIRECT_NOP_EN defined to expect the redirect bubble.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        bios_en, imem_en;
  logic [11:0] bios_addr;
  logic [13:0] imem_addr;
  logic [31:0] bios_dout = '0;
  logic [31:0] imem_dout = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc, out_inst;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

`ifdef FETCH_REDIRECT_NOP_EN
  localparam logic GapValid = 1'b1;
`else
  localparam logic GapValid = 1'b0;
`endif

  always #5 clk = ~clk;

  fetch_stage #(
    .DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .bios_en       (bios_en),
    .bios_addr     (bios_addr),
    .bios_dout     (bios_dout),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_dout     (imem_dout),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst)
  );

  // Synchronous memories with distinct contents per region; garbage when not enabled.
  always @(posedge clk) begin
    bios_dout <= bios_en ? (32'hB000_0000 | 32'(bios_addr)) : 32'hDEAD_BEEF;
    imem_dout <= imem_en ? (32'hA000_0000 | 32'(imem_addr)) : 32'hDEAD_BEEF;
  end

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    if (pc[30]) return 32'hB000_0000 | {20'h0, pc[13:2]};
    return 32'hA000_0000 | {18'h0, pc[15:2]};
  endfunction

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = exp_inst(pc);
    exp_q.push_back(e);
  endtask

  task automatic push_bubble();
`ifdef FETCH_REDIRECT_NOP_EN
    exp_t e;
    e.pc   = 32'h0;
    e.inst = 32'h0000_0013;
    exp_q.push_back(e);
`endif
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard compare on each handshake, plus the no-push-into-full rule.
  always @(negedge clk) begin
    if (rst_n) begin
      check("push_into_full",
            32'(dut.u_fifo.push && !dut.u_fifo.flush && !dut.u_fifo.pop &&
                (32'(dut.u_fifo.count) == DEPTH)), 32'h0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_pc", out_pc, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_pc", out_pc, mon_e.pc);
          check("out_inst", out_inst, mon_e.inst);
        end
      end
    end
  end

  initial begin
    logic [31:0] p;
    // Expected stream, derived from the cycle plan below.
    for (int i = 0; i < 14; i++) push_exp(32'h4000_0000 + 32'(4 * i));
    push_bubble();
    for (int i = 0; i < 5; i++) push_exp(32'h1000_0004 + 32'(4 * i));
    push_bubble();
    for (int i = 0; i < 5; i++) push_exp(32'h4000_0010 + 32'(4 * i));
    push_bubble();
    for (int i = 0; i < 6; i++) begin
      p = 32'hFFFF_FFF8 + 32'(4 * i);
      push_exp(p);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_inst", out_inst, 32'h0000_0013);
    check("rst_bios_en", 32'(bios_en), 32'h0);
    check("rst_imem_en", 32'(imem_en), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int cyc = 0; cyc < 46; cyc++) begin
      out_ready      = !((cyc >= 10 && cyc <= 14) || (cyc >= 26 && cyc <= 27) || cyc >= 42);
      redirect_valid = (cyc == 20) || (cyc == 28) || (cyc == 34);
      redirect_pc    = (cyc == 20) ? 32'h1000_0006 :
                       (cyc == 28) ? 32'h4000_0010 :
                       (cyc == 34) ? 32'hFFFF_FFF8 : 32'h0;
      @(negedge clk);
      if (cyc == 0) begin
        check("c0_bios_en", 32'(bios_en), 32'h1);
        check("c0_bios_addr", 32'(bios_addr), 32'h0);
        check("c0_imem_en", 32'(imem_en), 32'h0);
        check("c0_out_valid", 32'(out_valid), 32'h0);
      end
      if (cyc == 1) check("c1_out_valid", 32'(out_valid), 32'h0);
      if (cyc == 2) check("c2_out_valid", 32'(out_valid), 32'h1);
      if (cyc >= 10 && cyc <= 14) check("stall_enables", {30'h0, bios_en, imem_en}, 32'h0);
      if (cyc >= 11 && cyc <= 14) begin
        check("stall_out_pc", out_pc, 32'h4000_0020);
        check("stall_out_inst", out_inst, 32'hB000_0008);
      end
      if (cyc == 12) check("stall_fifo_count", 32'(dut.u_fifo.count), 32'h2);
      if (cyc == 20) begin
        check("redir_imem_en", 32'(imem_en), 32'h1);
        check("redir_imem_addr", 32'(imem_addr), 32'h1);
        check("redir_bios_en", 32'(bios_en), 32'h0);
      end
      if (cyc == 21 || cyc == 29 || cyc == 35) check("redir_gap_valid", 32'(out_valid), 32'(GapValid));
      if (cyc == 28) begin
        check("redir_b_bios_en", 32'(bios_en), 32'h1);
        check("redir_b_bios_addr", 32'(bios_addr), 32'h4);
      end
      if (cyc == 34) begin
        check("redir_c_bios_en", 32'(bios_en), 32'h1);
        check("redir_c_bios_addr", 32'(bios_addr), 32'hFFE);
      end
      if (cyc == 43) check("pre_reset_valid", 32'(out_valid), 32'h1);
      if (cyc == 44) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        check("midrst_out_inst", out_inst, 32'h0000_0013);
        check("midrst_bios_en", 32'(bios_en), 32'h0);
      end
      @(posedge clk);
      #1;
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
